// File: rtl/div_if.sv
// Request/response bundle between the EX stage and the iterative divider.
interface div_if;
  logic        start;
  logic        is_sign;
  logic        annul;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, is_sign, annul, a, b,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, is_sign, annul, a, b,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/div_unit.sv
// Iterative 32-bit restoring divider for DIV/DIVU: one quotient bit per cycle,
// remainder returned on hi and quotient on lo.
module div_unit (
  input  logic   clk,
  input  logic   rst,
  div_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      r_state;
  logic [4:0]  r_cnt;
  logic        r_busy;
  logic [31:0] r_hi;
  logic [31:0] r_lo;

  logic [31:0] r_dvd;
  logic [31:0] r_dvs;
  logic [31:0] r_rem;
  logic [31:0] r_quot;
  logic        r_sign_q;
  logic        r_sign_r;

  logic        w_accept;
  logic [32:0] w_rem33;
  logic        w_ge;
  logic [31:0] w_rem_nxt;
  logic [31:0] w_quot_nxt;

  // Two's-complement negate; the most negative value maps to itself.
  function automatic logic [31:0] f_neg(input logic [31:0] v);
    return ~v + 32'd1;
  endfunction

  // Magnitude of an operand; raw bits when the operation is unsigned.
  function automatic logic [31:0] f_abs(input logic [31:0] v, input logic is_signed);
    return (is_signed && v[31]) ? f_neg(v) : v;
  endfunction

  assign w_accept = bus.start & ~bus.annul;

  // One restoring step. When the subtraction is taken the true difference is
  // below the divisor, so a 32-bit subtract yields it exactly.
  assign w_rem33    = {r_rem, r_dvd[31]};
  assign w_ge       = (w_rem33 >= {1'b0, r_dvs});
  assign w_rem_nxt  = w_ge ? (w_rem33[31:0] - r_dvs) : w_rem33[31:0];
  assign w_quot_nxt = {r_quot[30:0], w_ge};

  // Control FSM with registered busy and result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= 5'd0;
      r_busy  <= 1'b0;
      r_hi    <= 32'd0;
      r_lo    <= 32'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            if (bus.b == 32'd0) begin
              r_state <= DONE;
              r_hi    <= bus.a;
              r_lo    <= 32'hFFFF_FFFF;
            end else begin
              r_state <= RUN;
              r_busy  <= 1'b1;
              r_cnt   <= 5'd0;
            end
          end
        end
        RUN: begin
          if (bus.annul) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 5'd1;
            if (r_cnt == 5'd31) begin
              r_state <= DONE;
              r_busy  <= 1'b0;
              r_lo    <= r_sign_q ? f_neg(w_quot_nxt) : w_quot_nxt;
              r_hi    <= r_sign_r ? f_neg(w_rem_nxt) : w_rem_nxt;
            end
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Datapath: load magnitudes on acceptance, shift/subtract while running.
  always_ff @(posedge clk) begin
    if (r_state == IDLE && w_accept) begin
      r_dvd    <= f_abs(bus.a, bus.is_sign);
      r_dvs    <= f_abs(bus.b, bus.is_sign);
      r_rem    <= 32'd0;
      r_quot   <= 32'd0;
      r_sign_q <= bus.is_sign & (bus.a[31] ^ bus.b[31]);
      r_sign_r <= bus.is_sign & bus.a[31];
    end else if (r_state == RUN) begin
      r_dvd  <= {r_dvd[30:0], 1'b0};
      r_rem  <= w_rem_nxt;
      r_quot <= w_quot_nxt;
    end
  end

  assign bus.busy = r_busy;
  assign bus.done = (r_state == DONE) & ~bus.annul;
  assign bus.hi   = r_hi;
  assign bus.lo   = r_lo;

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: driver pushes expected {hi,lo} per accepted
// request, a monitor pops and compares on every done pulse.
module tb_div_unit;

  logic clk;
  logic rst;
  div_if bus ();

  div_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_total;
  int          n_pass;
  int          n_done;
  logic [63:0] sb_q[$];
  logic [63:0] last_res;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
  endtask

  // Reference: plain integer division in 64-bit arithmetic (no overflow trap),
  // C-style truncation toward zero with remainder taking the dividend's sign.
  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic s);
    longint sa, sb, qq, rr;
    logic [31:0] uq, ur;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      qq = sa / sb;
      rr = sa % sb;
      return {rr[31:0], qq[31:0]};
    end
    uq = a / b;
    ur = a % b;
    return {ur, uq};
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (bus.done === 1'b1) begin
      n_done++;
      if (sb_q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        logic [63:0] e;
        e = sb_q.pop_front();
        check("hi", bus.hi, e[63:32]);
        check("lo", bus.lo, e[31:0]);
        last_res = e;
      end
    end
  end

  task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic s);
    int   n, busy_n;
    logic seen;
    sb_q.push_back(model(a, b, s));
    @(posedge clk); #1;
    bus.start = 1'b1; bus.a = a; bus.b = b; bus.is_sign = s;
    n = 0; busy_n = 0; seen = 1'b0;
    while (!seen && n < 40) begin
      @(negedge clk);
      if (bus.busy === 1'b1) busy_n++;
      if (bus.done === 1'b1) seen = 1'b1;
      else n++;
    end
    check("latency", n, (b == 32'd0) ? 32'd1 : 32'd33);
    check("busy_cycles", busy_n, (b == 32'd0) ? 32'd0 : 32'd32);
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(negedge clk);
    check("done_after", {31'd0, bus.done}, 32'd0);
  endtask

  initial begin
    int d0;
    n_total = 0; n_pass = 0; n_done = 0; last_res = 64'd0;
    rst = 1'b1;
    bus.start = 1'b0; bus.is_sign = 1'b0; bus.annul = 1'b0;
    bus.a = 32'd0; bus.b = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_done", {31'd0, bus.done}, 32'd0);
    check("rst_hi", bus.hi, 32'd0);
    check("rst_lo", bus.lo, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Directed cases
    run_div(32'd100, 32'd7, 1'b0);
    run_div(32'hFFFF_FFF9, 32'd2, 1'b1);
    run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_div(32'h0000_1234, 32'd0, 1'b0);
    run_div(32'hFFFF_FFF0, 32'd0, 1'b1);

    // Annul mid-run: no done, results untouched
    d0 = n_done;
    @(posedge clk); #1;
    bus.start = 1'b1; bus.a = 32'd50; bus.b = 32'd5; bus.is_sign = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    bus.annul = 1'b1; bus.start = 1'b0;
    @(posedge clk); #1;
    bus.annul = 1'b0;
    @(negedge clk);
    check("annul_busy", {31'd0, bus.busy}, 32'd0);
    check("annul_hi", bus.hi, last_res[63:32]);
    check("annul_lo", bus.lo, last_res[31:0]);
    repeat (40) @(posedge clk);
    check("annul_no_done", n_done, d0);
    run_div(32'hFFFF_FFFF, 32'd1, 1'b0);

    // Annul in IDLE: request not accepted
    d0 = n_done;
    @(posedge clk); #1;
    bus.start = 1'b1; bus.annul = 1'b1; bus.a = 32'd77; bus.b = 32'd3;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.annul = 1'b0;
    @(negedge clk);
    check("idle_annul_busy", {31'd0, bus.busy}, 32'd0);
    repeat (40) @(posedge clk);
    check("idle_annul_no_done", n_done, d0);

    // Reset mid-run
    d0 = n_done;
    @(posedge clk); #1;
    bus.start = 1'b1; bus.a = 32'd1000; bus.b = 32'hFFFF_FFF9; bus.is_sign = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    rst = 1'b1; bus.start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("mrst_busy", {31'd0, bus.busy}, 32'd0);
    check("mrst_done", {31'd0, bus.done}, 32'd0);
    check("mrst_hi", bus.hi, 32'd0);
    check("mrst_lo", bus.lo, 32'd0);
    repeat (40) @(posedge clk);
    check("mrst_no_done", n_done, d0);
    run_div(32'd9, 32'hFFFF_FFFD, 1'b1);

    // Randomized operands, including small divisors, zero and sign extremes
    for (int i = 0; i < 24; i++) begin
      logic [31:0] ra, rb;
      ra = $urandom;
      case ($urandom_range(0, 4))
        0: rb = 32'd0;
        1: rb = $urandom_range(1, 15);
        2: rb = 32'h0 - $urandom_range(1, 15);
        3: rb = 32'h8000_0000;
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 5) == 0) ra = 32'h8000_0000;
      run_div(ra, rb, 1'($urandom_range(0, 1)));
    end

    repeat (3) @(posedge clk);
    check("sb_empty", sb_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
